// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller
// between the CPU MEM stage and a line-wide off-chip data memory.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   p1_*  : CPU side (addr, store data, memrd/memwr, load data, stall)
//   mem_* : memory side (enable, write, line addr, line data out/in, ack)
//   hit_cnt_o, miss_cnt_o : present only when DCACHE_STATS_EN is defined
module dcache_ctrl #(
    parameter int TAG_W  = 22,
    parameter int IDX_W  = 5,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_memrd_i,
    input  logic              p1_memwr_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE, WRITEBACK, ALLOCATE, REFILL
    } state_t;

    state_t              state_q;
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINE_W-1:0]   data_q [LINES];
    logic                mem_en_q;
    logic                mem_wr_q;
    logic [31:0]         mem_addr_q;
    logic [LINE_W-1:0]   mem_data_q;
    logic [31:0]         rdata_q;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [2:0]          wsel;
    logic                req;
    logic                is_rd;
    logic                hit;
    logic [LINE_W-1:0]   line;
    logic [LINE_W-1:0]   line_d;
    logic [31:0]         word;
    logic                unused_addr;

    assign idx   = p1_addr_i[9:5];
    assign tag   = p1_addr_i[31:10];
    assign wsel  = p1_addr_i[4:2];
    assign req   = p1_memrd_i | p1_memwr_i;
    // a simultaneous read+write request is a store
    assign is_rd = p1_memrd_i & ~p1_memwr_i;
    assign hit   = valid_q[idx] & (tag_q[idx] == tag);
    assign line  = data_q[idx];
    assign word  = line[{wsel, 5'd0} +: 32];
    assign unused_addr = ^p1_addr_i[1:0];

    always_comb begin
        line_d = line;
        line_d[{wsel, 5'd0} +: 32] = p1_data_i;
    end

    assign p1_data_o = (state_q == IDLE && is_rd && hit) ? word : rdata_q;
    // gated by reset so the stall drops the instant reset asserts
    assign p1_stall_o = rst_i &
                        ((state_q != IDLE) | (req & ~hit));

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // line storage carries no reset; valid bits alone qualify it
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && req && hit && p1_memwr_i) begin
            data_q[idx] <= line_d;
        end else if (state_q == ALLOCATE && mem_ack_i) begin
            data_q[idx] <= mem_data_i;
            tag_q[idx]  <= tag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        if (p1_memwr_i) dirty_q[idx] <= 1'b1;
                        else            rdata_q      <= word;
                    end else if (req) begin
                        mem_en_q <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q    <= WRITEBACK;
                            mem_wr_q   <= 1'b1;
                            mem_addr_q <= {tag_q[idx], idx, 5'd0};
                            mem_data_q <= line;
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_wr_q   <= 1'b0;
                            mem_addr_q <= {tag, idx, 5'd0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q    <= ALLOCATE;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= {tag, idx, 5'd0};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q      <= REFILL;
                        mem_en_q     <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                REFILL: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic        replay_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // replay_q marks the IDLE cycle that re-runs a refilled miss
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            replay_q <= (state_q == REFILL);
            if (state_q == IDLE && req) begin
                if (hit && !replay_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
                else if (!hit)        miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl with a line memory model that
// acks in the L-th cycle of a request and idles one cycle after each ack.
module tb_dcache_ctrl;

    localparam int L = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic         p1_memrd_i = 1'b0;
    logic         p1_memwr_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .p1_addr_i   (p1_addr_i),
        .p1_data_i   (p1_data_i),
        .p1_memrd_i  (p1_memrd_i),
        .p1_memwr_i  (p1_memwr_i),
        .p1_data_o   (p1_data_o),
        .p1_stall_o  (p1_stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    logic [255:0] mem [128];
    int           mcnt = 0;
    int           nrd = 0;
    int           nwr = 0;
    int           evn = 0;
    int           rd_seq = 0;
    int           wr_seq = 0;
    logic [31:0]  rd_addr = '0;
    logic [31:0]  wr_addr = '0;

    initial begin
        for (int i = 0; i < 128; i++) begin
            for (int w = 0; w < 8; w++) begin
                mem[i][w*32 +: 32] = {16'(i), 16'(w)};
            end
        end
        mem[32][63:32] = 32'hDEAD_BEEF;
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            mem_ack_i = 1'b0;
            mcnt = 0;
        end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            mcnt = 0;
        end else if (mem_enable_o) begin
            mcnt++;
            if (mcnt == L) begin
                mem_ack_i = 1'b1;
                evn++;
                if (mem_write_o) begin
                    mem[mem_addr_o[11:5]] = mem_data_o;
                    nwr++;
                    wr_seq = evn;
                    wr_addr = mem_addr_o;
                end else begin
                    mem_data_i = mem[mem_addr_o[11:5]];
                    nrd++;
                    rd_seq = evn;
                    rd_addr = mem_addr_o;
                end
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic rd, input logic wr,
                          output int stalls, output logic [31:0] rdata,
                          output logic tmo);
        @(posedge clk_i);
        #1;
        p1_addr_i = a;
        p1_data_i = d;
        p1_memrd_i = rd;
        p1_memwr_i = wr;
        stalls = 0;
        tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (!p1_stall_o) begin
                tmo = 1'b0;
                break;
            end
            stalls++;
        end
        rdata = p1_data_o;
        @(posedge clk_i);
        #1;
        p1_memrd_i = 1'b0;
        p1_memwr_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if (p1_stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", p1_stall_o);
        else passes++;
        checks++;
        if (mem_enable_o !== 1'b0) $display("FAIL rst_en: got %b want 0", mem_enable_o);
        else passes++;
        checks++;
        if (mem_write_o !== 1'b0) $display("FAIL rst_wr: got %b want 0", mem_write_o);
        else passes++;
        checks++;
        if (mem_addr_o !== 32'h0) $display("FAIL rst_addr: got %h want 0", mem_addr_o);
        else passes++;
        checks++;
        if (mem_data_o !== 256'h0) $display("FAIL rst_mdata: got %h want 0", mem_data_o);
        else passes++;
        checks++;
        if (p1_data_o !== 32'h0) $display("FAIL rst_pdata: got %h want 0", p1_data_o);
        else passes++;
        rst_i = 1'b1;
    endtask

    task automatic test_cold_load();
        int st;
        logic [31:0] rdat;
        logic tmo;
        int r0 = nrd;
        int w0 = nwr;
        access(32'h404, 32'h0, 1'b1, 1'b0, st, rdat, tmo);
        checks++;
        if (tmo || st != 12) $display("FAIL cold_stall: got %0d want 12", st);
        else passes++;
        checks++;
        if (nrd - r0 != 1 || rd_addr !== 32'h400)
            $display("FAIL cold_read: got %0d reads at %h want 1 at 00000400", nrd - r0, rd_addr);
        else passes++;
        checks++;
        if (nwr != w0) $display("FAIL cold_nowb: got %0d writes want 0", nwr - w0);
        else passes++;
        checks++;
        if (rdat !== 32'hDEAD_BEEF) $display("FAIL cold_data: got %h want deadbeef", rdat);
        else passes++;
    endtask

    task automatic test_hit();
        int st;
        logic [31:0] rdat;
        logic tmo;
        int e0 = evn;
        access(32'h404, 32'h1234_5678, 1'b0, 1'b1, st, rdat, tmo);
        checks++;
        if (tmo || st != 0) $display("FAIL st_hit_stall: got %0d want 0", st);
        else passes++;
        access(32'h404, 32'h0, 1'b1, 1'b0, st, rdat, tmo);
        checks++;
        if (tmo || st != 0) $display("FAIL ld_hit_stall: got %0d want 0", st);
        else passes++;
        checks++;
        if (rdat !== 32'h1234_5678) $display("FAIL ld_hit_data: got %h want 12345678", rdat);
        else passes++;
        checks++;
        if (evn != e0) $display("FAIL hit_traffic: got %0d transfers want 0", evn - e0);
        else passes++;
    endtask

    task automatic test_dirty_miss();
        int st;
        logic [31:0] rdat;
        logic tmo;
        int r0 = nrd;
        int w0 = nwr;
        access(32'h804, 32'h0, 1'b1, 1'b0, st, rdat, tmo);
        checks++;
        if (tmo || st != 23) $display("FAIL dirty_stall: got %0d want 23", st);
        else passes++;
        checks++;
        if (nwr - w0 != 1 || wr_addr !== 32'h400)
            $display("FAIL dirty_wb: got %0d writes at %h want 1 at 00000400", nwr - w0, wr_addr);
        else passes++;
        checks++;
        if (mem[32][63:32] !== 32'h1234_5678)
            $display("FAIL dirty_wbdata: got %h want 12345678", mem[32][63:32]);
        else passes++;
        checks++;
        if (nrd - r0 != 1 || rd_addr !== 32'h800)
            $display("FAIL dirty_read: got %0d reads at %h want 1 at 00000800", nrd - r0, rd_addr);
        else passes++;
        checks++;
        if (!(wr_seq < rd_seq)) $display("FAIL dirty_order: got wr %0d rd %0d want wr first", wr_seq, rd_seq);
        else passes++;
        checks++;
        if (rdat !== 32'h0040_0001) $display("FAIL dirty_data: got %h want 00400001", rdat);
        else passes++;
    endtask

    task automatic test_clean_reload();
        int st;
        logic [31:0] rdat;
        logic tmo;
        int r0 = nrd;
        int w0 = nwr;
        int e0;
        access(32'h400, 32'h0, 1'b1, 1'b0, st, rdat, tmo);
        checks++;
        if (tmo || st != 12) $display("FAIL reload_stall: got %0d want 12", st);
        else passes++;
        checks++;
        if (nwr != w0 || nrd - r0 != 1 || rd_addr !== 32'h400)
            $display("FAIL reload_traffic: got w%0d r%0d at %h want w0 r1 at 00000400", nwr - w0, nrd - r0, rd_addr);
        else passes++;
        checks++;
        if (rdat !== 32'h0020_0000) $display("FAIL reload_data: got %h want 00200000", rdat);
        else passes++;
`ifdef DCACHE_STATS_EN
        checks++;
        if (hit_cnt_o !== 32'd2) $display("FAIL stats_hit: got %0d want 2", hit_cnt_o);
        else passes++;
        checks++;
        if (miss_cnt_o !== 32'd3) $display("FAIL stats_miss: got %0d want 3", miss_cnt_o);
        else passes++;
`endif
        e0 = evn;
        access(32'h404, 32'h0, 1'b1, 1'b0, st, rdat, tmo);
        checks++;
        if (tmo || st != 0 || evn != e0) $display("FAIL reload_w1_hit: got stall %0d want 0", st);
        else passes++;
        checks++;
        if (rdat !== 32'h1234_5678) $display("FAIL reload_w1: got %h want 12345678", rdat);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int st;
        logic [31:0] rdat;
        logic tmo;
        int r0;
        @(posedge clk_i);
        #1;
        p1_addr_i = 32'hC04;
        p1_memrd_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (p1_stall_o !== 1'b1 || mem_enable_o !== 1'b0)
            $display("FAIL mid_detect: got stall %b en %b want 1 0", p1_stall_o, mem_enable_o);
        else passes++;
        @(negedge clk_i);
        checks++;
        if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'hC00)
            $display("FAIL mid_alloc: got en %b wr %b addr %h want 1 0 00000c00", mem_enable_o, mem_write_o, mem_addr_o);
        else passes++;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (mem_enable_o !== 1'b0 || p1_stall_o !== 1'b0)
            $display("FAIL mid_rst_drop: got en %b stall %b want 0 0", mem_enable_o, p1_stall_o);
        else passes++;
        p1_memrd_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
`ifdef DCACHE_STATS_EN
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0)
            $display("FAIL stats_rst: got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o);
        else passes++;
`endif
        r0 = nrd;
        access(32'h404, 32'h0, 1'b1, 1'b0, st, rdat, tmo);
        checks++;
        if (tmo || st != 12 || nrd - r0 != 1)
            $display("FAIL post_rst_miss: got stall %0d reads %0d want 12 1", st, nrd - r0);
        else passes++;
        checks++;
        if (rdat !== 32'h1234_5678) $display("FAIL post_rst_data: got %h want 12345678", rdat);
        else passes++;
`ifdef DCACHE_STATS_EN
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd1)
            $display("FAIL stats_post: got %0d/%0d want 0/1", hit_cnt_o, miss_cnt_o);
        else passes++;
`endif
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_hit();
        test_dirty_miss();
        test_clean_reload();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
